id_inst_queue: RTL and testbench

//  Parametrised instruction queue between the IF and ID stages; replaces the single IF->ID register.

---
 rtl/id_inst_queue.sv | 117 +++++++++++
 tb/tb_id_inst_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_queue.sv
// rtl/id_inst_queue.sv - IF->ID instruction queue with flush and stall/flush performance counters
// Optional zero-latency empty path: define ID_IQ_BYPASS_EN.
module id_inst_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic empty;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (occ_q == '0);

`ifdef ID_IQ_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Allowin looks only at registered occupancy so IF never waits on ID's ready.
  assign in_allowin = (occ_q != FULL_OCC);
  assign out_valid  = ~empty | bypass;
  assign out_data   = bypass ? in_data : mem_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // A bypassed packet taken by ID in the same cycle never touches storage.
  assign push = in_valid & in_allowin & ~flush & ~(bypass & out_ready);
  assign pop  = ~empty & out_ready & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Packet storage carries no reset; contents are meaningless while occupancy is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// tb/tb_id_inst_queue.sv - vector table plus scoreboard bench for id_inst_queue
module tb_id_inst_queue;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
`ifdef ID_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_allowin;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              flush = 1'b0;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  id_inst_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int pushcnt = 0;
  logic [DATA_W-1:0] sb [$];

  typedef struct {
    logic iv; logic rdy; logic fl;
    logic ev; logic ea; int eo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pkt(input int k);
    logic [31:0] pc;
    pc = 32'h1c00_0000 + 32'(k * 4);
    return {~pc, pc};
  endfunction

  // Drive one cycle at the falling edge and check pre-edge outputs; expectations
  // are written for the registered path, bypass adds a same-cycle head when empty.
  task automatic step(input logic iv, input logic rdy, input logic fl,
                      input logic ev, input logic ea, input int eo);
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    logic evx;
    @(negedge clk);
    d = pkt(pushcnt);
    in_valid = iv; in_data = d; out_ready = rdy; flush = fl;
    evx = ev;
    if (BYP && eo == 0 && iv && !fl) evx = 1'b1;
    #1;
    chk("out_valid", 64'(out_valid), 64'(evx));
    chk("in_allowin", 64'(in_allowin), 64'(ea));
    chk("occupancy", 64'(occupancy), 64'(eo));
    if (iv && ea && !fl) begin
      sb.push_back(d);
      pushcnt++;
    end
    if (evx && rdy && !fl) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e);
      end
    end
    if (fl) sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    pushcnt = 0;
  endtask

  task automatic peek();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  vec_t tbl [$];

  initial begin
    // fill to full, 5th offer held, then drain in order
    tbl.push_back('{1,0,0, 0,1,0});
    tbl.push_back('{1,0,0, 1,1,1});
    tbl.push_back('{1,0,0, 1,1,2});
    tbl.push_back('{1,0,0, 1,1,3});
    tbl.push_back('{1,0,0, 1,0,4});
    tbl.push_back('{0,1,0, 1,0,4});
    tbl.push_back('{0,1,0, 1,1,3});
    tbl.push_back('{0,1,0, 1,1,2});
    tbl.push_back('{0,1,0, 1,1,1});
    tbl.push_back('{0,0,0, 0,1,0});
    // full: a pop in the same cycle does not admit a push
    tbl.push_back('{1,0,0, 0,1,0});
    tbl.push_back('{1,0,0, 1,1,1});
    tbl.push_back('{1,0,0, 1,1,2});
    tbl.push_back('{1,0,0, 1,1,3});
    tbl.push_back('{1,1,0, 1,0,4});
    tbl.push_back('{0,0,0, 1,1,3});
    tbl.push_back('{0,0,1, 1,1,3});
    tbl.push_back('{0,0,0, 0,1,0});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_allowin", 64'(in_allowin), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, tbl[i].rdy, tbl[i].fl, tbl[i].ev, tbl[i].ea, tbl[i].eo);
    end
    peek();
    chk("table_flush_cnt", 64'(flush_cnt), 64'd1);

    // wrap: ten packets with push and pop every cycle
    do_reset();
    step(1, 1, 0, 0, 1, 0);
    for (int i = 1; i < 10; i++) begin
      step(1, 1, 0, 1, 1, BYP ? 0 : 1);
    end
    step(0, 1, 0, BYP ? 1'b0 : 1'b1, 1, BYP ? 0 : 1);
    step(0, 0, 0, 0, 1, 0);
    chk("wrap_all_consumed", 64'(sb.size()), 64'd0);
    chk("wrap_push_count", 64'(pushcnt), 64'd10);

    // flush with three held and a packet offered
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 2);
    step(1, 0, 1, 1, 1, 3);
    step(0, 0, 0, 0, 1, 0);
    chk("flush_cnt_one", 64'(flush_cnt), 64'd1);

    // stall counter and saturation
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 1);
    peek();
    chk("stall_cnt_7", 64'(stall_cnt), BYP ? 64'd8 : 64'd7);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 1, 1);
    peek();
    chk("stall_cnt_sat", 64'(stall_cnt), 64'd15);

    // empty-queue latency with out_ready held
    do_reset();
    pushcnt = 16;
    step(1, 1, 0, 0, 1, 0);
    step(0, 1, 0, BYP ? 1'b0 : 1'b1, 1, BYP ? 0 : 1);
    step(0, 0, 0, 0, 1, 0);
    chk("bypass_drained", 64'(sb.size()), 64'd0);

    // asynchronous reset mid-stream with three held
    do_reset();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 2);
    step(0, 0, 1, 1, 1, 3);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 2);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_allowin", 64'(in_allowin), 64'd1);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    #1;
    chk("arst_hold_occupancy", 64'(occupancy), 64'd0);
    reset = 1'b0;
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
